cr16_control_fsm: RTL and testbench
===================================

// Module: cr16_control_fsm
// PURPOSE
//  Multi-cycle fetch/decode/execute controller for the CR16-subset datapath; directly upstream of RegFile.
//  Holds PC and IR, decodes each instruction, drives RegFile read addresses and write enable, ALU op,
//  immediate, flag-register enable and data-memory strobes. Branch decisions come from the flag register.
// PARAMETERS
//  RESET_PC  16'h0000  PC value loaded on reset
// PORTS
//  Clk          in   1   system clock, rising edge
//  Rst          in   1   asynchronous, active-high reset
//  Instr        in   16  instruction memory read data, valid during the cycle after PcOut is presented
//  Flags        in   5   flag register {C,L,F,Z,N}
//  PcOut        out  16  instruction memory address
//  RdestRegLoc  out  4   RegFile Rdest select (read port and write address)
//  RsrcRegLoc   out  4   RegFile Rsrc select (read port; load/store address register)
//  RegEn        out  1   RegFile write enable, 1 cycle per writing instruction
//  AluOp        out  4   ALU op code (values in package)
//  ImmSel       out  1   1 = ALU B operand is Imm, 0 = RsrcOut
//  Imm          out  16  extended immediate
//  FlagsEn      out  1   flag register load enable
//  MemWe        out  1   data memory write strobe (addr = RsrcOut, data = RdestOut)
//  MemToReg     out  1   1 = RegFile Load mux selects memory read data
//  Halt         out  1   1 = illegal opcode trapped
// BEHAVIOUR
//  Reset: async; State=FETCH, PC=RESET_PC, IR=0; all enables, ImmSel, MemToReg and Halt =0; Imm=0.
//   Reset asserted mid-instruction aborts it: no RegEn/MemWe/FlagsEn pulse after Rst rises.
//  States: FETCH -> DECODE -> EXEC -> FETCH; a load inserts MEM after EXEC; illegal opcode -> HALT.
//   FETCH: PcOut=PC; IR<=Instr on exit. DECODE: Rdest=IR[11:8], Rsrc=IR[3:0] stable for the RegFile read.
//   EXEC: ALU/imm ops: RegEn=1 (except CMP/CMPI); FlagsEn=1 for ADD/SUB/CMP (reg and imm forms) only.
//   STOR: MemWe=1 for exactly one cycle. LOAD: EXEC issues the address; MEM: MemToReg=1, RegEn=1.
//   Bcond: PC<=PC+sext(IR[7:0]) if cond true, else PC+1. All other instructions: PC<=PC+1 on leaving EXEC/MEM.
//  Latency (cycles): ALU/imm/store/branch = 3, load = 4; a new FETCH always follows.
//  Outputs are a pure function of State and IR; RdestRegLoc/RsrcRegLoc hold from DECODE to the end of the instruction.
//  Decode (IR[15:12] op, [7:4] ext):
//   op 0000 RR: ext ADD 0101, SUB 1001, CMP 1011, AND 0001, OR 0010, XOR 0011, MOV 1101.
//   Immediate: op = same codes; imm8 = IR[7:0]. ADDI/SUBI/CMPI sign-extend; ANDI/ORI/XORI/MOVI zero-extend.
//   op 0100: ext 0000 LOAD Rdest<=mem[Rsrc], ext 0100 STOR mem[Rsrc]<=Rdest. op 1100 Bcond: cond=IR[11:8].
//   Any other op or ext is illegal: HALT, Halt=1, all enables 0, PC frozen; only Rst exits.
//  Conditions: EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; HI 0100 L; LS 0101 !L; GT 0110 N; LE 0111 !N.
//   FS 1000 F; FC 1001 !F; LO 1010 !L&!Z; HS 1011 L|Z; LT 1100 !N&!Z; GE 1101 N|Z; UC 1110 1; 1111 0.
//  Width rules: PC arithmetic is mod 2^16 (FFFF+1=0000; branch wrap allowed). Rdest==Rsrc is legal.
//   Writes to R0 are normal writes; R0 is not hardwired to zero.
//  Flags are sampled in EXEC; an instruction's own FlagsEn takes effect at the next instruction.
// STRUCTURE
//  Shared package cr16_defs.vh: state encodings, opcode/ext constants, cond codes, AluOp values.
//  Sub-module branch_cond_eval (combinational): cond[3:0] + Flags -> take.
// TESTING
//  Reset: hold Rst 2 cycles, release -> PcOut=0000, RegEn=MemWe=FlagsEn=Halt=0; FETCH on next edge.
//  ADDI R3,#-1 (5 3 FF): EXEC shows RegEn=1, FlagsEn=1, ImmSel=1, Imm=FFFF, Rdest=3, AluOp=ADD; PcOut 0->1.
//  LOAD R2,[R7] (4 2 0 7): 4 cycles; MEM shows MemToReg=1 and RegEn=1; STOR shows one MemWe pulse, no RegEn.
//  BEQ -2 at PC=0010: Z=1 -> PC 000E; Z=0 -> 0011. UC at PC=FFFF with disp +1 -> 0000.
//  Illegal op 0xF000 -> Halt=1, PcOut frozen for 20 cycles; Rst during EXEC of ADD -> no RegEn pulse.

Source files
------------

// File: rtl/cr16_control_fsm_pkg.sv
// Shared definitions for the CR16-subset control FSM: states, opcode/ext
// fields, branch condition codes, ALU op values and the instruction decoder.
package cr16_control_fsm_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Major opcodes in IR[15:12]
    localparam logic [3:0] OP_RR    = 4'b0000;
    localparam logic [3:0] OP_LDST  = 4'b0100;
    localparam logic [3:0] OP_BCOND = 4'b1100;

    // ALU operation codes: IR[7:4] for register forms, IR[15:12] for immediate forms
    localparam logic [3:0] EXT_AND = 4'b0001;
    localparam logic [3:0] EXT_OR  = 4'b0010;
    localparam logic [3:0] EXT_XOR = 4'b0011;
    localparam logic [3:0] EXT_ADD = 4'b0101;
    localparam logic [3:0] EXT_SUB = 4'b1001;
    localparam logic [3:0] EXT_CMP = 4'b1011;
    localparam logic [3:0] EXT_MOV = 4'b1101;

    // Load/store selectors in IR[7:4] under OP_LDST
    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;

    // Branch condition codes in IR[11:8]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_HI = 4'b0100;
    localparam logic [3:0] COND_LS = 4'b0101;
    localparam logic [3:0] COND_GT = 4'b0110;
    localparam logic [3:0] COND_LE = 4'b0111;
    localparam logic [3:0] COND_FS = 4'b1000;
    localparam logic [3:0] COND_FC = 4'b1001;
    localparam logic [3:0] COND_LO = 4'b1010;
    localparam logic [3:0] COND_HS = 4'b1011;
    localparam logic [3:0] COND_LT = 4'b1100;
    localparam logic [3:0] COND_GE = 4'b1101;
    localparam logic [3:0] COND_UC = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // ALU op codes presented on AluOp (CMP uses SUB with the write suppressed)
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_MOV = 4'd5
    } alu_op_t;

    // Instruction classes that steer the FSM
    typedef enum logic [2:0] {
        IC_ILLEGAL = 3'd0,
        IC_ALU     = 3'd1,
        IC_LOAD    = 3'd2,
        IC_STOR    = 3'd3,
        IC_BRANCH  = 3'd4
    } iclass_t;

    // Everything the FSM needs to know about the instruction held in IR
    typedef struct packed {
        iclass_t iclass;
        alu_op_t alu_op;
        logic    imm_form;    // B operand comes from Imm
        logic    imm_sext;    // imm8 is sign-extended (ADDI/SUBI/CMPI)
        logic    writes_reg;  // result written to Rdest
        logic    sets_flags;  // flag register loaded
    } decode_t;

    // Decode one instruction word into its control summary
    function automatic decode_t decode_ir(input logic [15:0] ir);
        decode_t    d;
        logic [3:0] op;
        logic [3:0] ext;
        logic [3:0] code;
        logic       code_ok;
        logic       arith;

        d       = '{iclass: IC_ILLEGAL, alu_op: ALU_ADD, imm_form: 1'b0,
                    imm_sext: 1'b0, writes_reg: 1'b0, sets_flags: 1'b0};
        op      = ir[15:12];
        ext     = ir[7:4];
        code    = (op == OP_RR) ? ext : op;
        code_ok = 1'b1;

        case (code)
            EXT_ADD: d.alu_op = ALU_ADD;
            EXT_SUB: d.alu_op = ALU_SUB;
            EXT_CMP: d.alu_op = ALU_SUB;
            EXT_AND: d.alu_op = ALU_AND;
            EXT_OR:  d.alu_op = ALU_OR;
            EXT_XOR: d.alu_op = ALU_XOR;
            EXT_MOV: d.alu_op = ALU_MOV;
            default: code_ok  = 1'b0;
        endcase

        arith = (code == EXT_ADD) || (code == EXT_SUB) || (code == EXT_CMP);

        if (op == OP_LDST) begin
            d.alu_op = ALU_ADD;
            if (ext == EXT_LOAD)
                d.iclass = IC_LOAD;
            else if (ext == EXT_STOR)
                d.iclass = IC_STOR;
        end else if (op == OP_BCOND) begin
            d.alu_op = ALU_ADD;
            d.iclass = IC_BRANCH;
        end else if (code_ok) begin
            d.iclass     = IC_ALU;
            d.imm_form   = (op != OP_RR);
            d.imm_sext   = (op != OP_RR) && arith;
            d.writes_reg = (code != EXT_CMP);
            d.sets_flags = arith;
        end else begin
            d.alu_op = ALU_ADD;
        end
        return d;
    endfunction

endpackage

// File: rtl/cr16_control_fsm_branch_cond_eval.sv
// Combinational branch condition evaluator: condition code + {C,L,F,Z,N} -> take.
module cr16_control_fsm_branch_cond_eval
    import cr16_control_fsm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       take
);

    logic c_flag, l_flag, f_flag, z_flag, n_flag;

    assign {c_flag, l_flag, f_flag, z_flag, n_flag} = flags;

    // Map the condition code onto the flag register
    always_comb begin
        take = 1'b0;
        case (cond)
            COND_EQ: take = z_flag;
            COND_NE: take = ~z_flag;
            COND_CS: take = c_flag;
            COND_CC: take = ~c_flag;
            COND_HI: take = l_flag;
            COND_LS: take = ~l_flag;
            COND_GT: take = n_flag;
            COND_LE: take = ~n_flag;
            COND_FS: take = f_flag;
            COND_FC: take = ~f_flag;
            COND_LO: take = ~l_flag & ~z_flag;
            COND_HS: take = l_flag | z_flag;
            COND_LT: take = ~n_flag & ~z_flag;
            COND_GE: take = n_flag | z_flag;
            COND_UC: take = 1'b1;
            COND_NV: take = 1'b0;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/cr16_control_fsm.sv
// Multi-cycle fetch/decode/execute controller for the CR16-subset datapath.
// Holds PC and IR; every datapath control output is a function of state and IR.
module cr16_control_fsm
    import cr16_control_fsm_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] Instr,
    input  logic [4:0]  Flags,
    output logic [15:0] PcOut,
    output logic [3:0]  RdestRegLoc,
    output logic [3:0]  RsrcRegLoc,
    output logic        RegEn,
    output logic [3:0]  AluOp,
    output logic        ImmSel,
    output logic [15:0] Imm,
    output logic        FlagsEn,
    output logic        MemWe,
    output logic        MemToReg,
    output logic        Halt
);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q;
    decode_t     dec;
    logic        take;
    logic [15:0] imm_ext;
    logic [15:0] br_disp;

    assign dec     = decode_ir(ir_q);
    assign imm_ext = dec.imm_sext ? {{8{ir_q[7]}}, ir_q[7:0]} : {8'h00, ir_q[7:0]};
    assign br_disp = {{8{ir_q[7]}}, ir_q[7:0]};

    // Register selects come straight from IR, so they hold for the whole instruction
    assign PcOut       = pc_q;
    assign RdestRegLoc = ir_q[11:8];
    assign RsrcRegLoc  = ir_q[3:0];

    cr16_control_fsm_branch_cond_eval u_branch_cond_eval (
        .cond  (ir_q[11:8]),
        .flags (Flags),
        .take  (take)
    );

    // State, PC and IR registers; IR captures the fetched word when leaving FETCH
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == ST_FETCH)
                ir_q <= Instr;
        end
    end

    // Next state, next PC and Moore-style datapath controls
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        RegEn    = 1'b0;
        FlagsEn  = 1'b0;
        MemWe    = 1'b0;
        MemToReg = 1'b0;
        ImmSel   = 1'b0;
        Imm      = '0;
        AluOp    = ALU_ADD;
        Halt     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                state_d = ST_DECODE;
            end

            ST_DECODE: begin
                state_d = (dec.iclass == IC_ILLEGAL) ? ST_HALT : ST_EXEC;
            end

            ST_EXEC: begin
                case (dec.iclass)
                    IC_ALU: begin
                        AluOp   = dec.alu_op;
                        ImmSel  = dec.imm_form;
                        Imm     = dec.imm_form ? imm_ext : 16'h0000;
                        RegEn   = dec.writes_reg;
                        FlagsEn = dec.sets_flags;
                        pc_d    = pc_q + 16'd1;
                        state_d = ST_FETCH;
                    end
                    IC_STOR: begin
                        MemWe   = 1'b1;
                        pc_d    = pc_q + 16'd1;
                        state_d = ST_FETCH;
                    end
                    IC_LOAD: begin
                        // Address (RsrcOut) is presented this cycle; data returns in MEM
                        state_d = ST_MEM;
                    end
                    IC_BRANCH: begin
                        pc_d    = take ? (pc_q + br_disp) : (pc_q + 16'd1);
                        state_d = ST_FETCH;
                    end
                    default: begin
                        state_d = ST_HALT;
                    end
                endcase
            end

            ST_MEM: begin
                MemToReg = 1'b1;
                RegEn    = 1'b1;
                pc_d     = pc_q + 16'd1;
                state_d  = ST_FETCH;
            end

            ST_HALT: begin
                Halt    = 1'b1;
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_cr16_control_fsm.sv
// Directed self-checking bench for cr16_control_fsm. Instr is driven by the
// bench while the DUT sits in FETCH; outputs are sampled 1 ns after each edge.
module tb_cr16_control_fsm;
    import cr16_control_fsm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic [4:0]  flags;
    logic [15:0] pc_out;
    logic [3:0]  rdest_reg_loc;
    logic [3:0]  rsrc_reg_loc;
    logic        reg_en;
    logic [3:0]  alu_op;
    logic        imm_sel;
    logic [15:0] imm;
    logic        flags_en;
    logic        mem_we;
    logic        mem_to_reg;
    logic        halt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    cr16_control_fsm #(.RESET_PC(16'h0000)) dut (
        .Clk         (clk),
        .Rst         (rst),
        .Instr       (instr),
        .Flags       (flags),
        .PcOut       (pc_out),
        .RdestRegLoc (rdest_reg_loc),
        .RsrcRegLoc  (rsrc_reg_loc),
        .RegEn       (reg_en),
        .AluOp       (alu_op),
        .ImmSel      (imm_sel),
        .Imm         (imm),
        .FlagsEn     (flags_en),
        .MemWe       (mem_we),
        .MemToReg    (mem_to_reg),
        .Halt        (halt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run a branch from FETCH with the given flags and check the resulting PC
    task automatic run_branch(input string tag, input logic [15:0] ins,
                              input logic [4:0] fl, input logic [15:0] exp_pc);
        flags = fl;
        instr = ins;
        tick();                               // DECODE
        tick();                               // EXEC
        check({tag, "_exec_regen"}, 16'(reg_en), 16'h0);
        check({tag, "_exec_memwe"}, 16'(mem_we), 16'h0);
        tick();                               // FETCH
        check({tag, "_pc"}, pc_out, exp_pc);
    endtask

    initial begin
        rst   = 1'b1;
        instr = 16'h0000;
        flags = 5'b00000;

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_pc", pc_out, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_pc",    pc_out,         16'h0000);
        check("rst_regen", 16'(reg_en),    16'h0);
        check("rst_memwe", 16'(mem_we),    16'h0);
        check("rst_flgen", 16'(flags_en),  16'h0);
        check("rst_halt",  16'(halt),      16'h0);
        check("rst_immsel",16'(imm_sel),   16'h0);
        check("rst_imm",   imm,            16'h0000);
        check("rst_m2r",   16'(mem_to_reg),16'h0);

        // ADDI R3,#-1 at PC 0000
        instr = 16'h53FF;
        tick();
        check("addi_dec_regen", 16'(reg_en),        16'h0);
        check("addi_dec_rdest", 16'(rdest_reg_loc), 16'h3);
        check("addi_dec_rsrc",  16'(rsrc_reg_loc),  16'hF);
        tick();
        check("addi_regen",  16'(reg_en),        16'h1);
        check("addi_flgen",  16'(flags_en),      16'h1);
        check("addi_immsel", 16'(imm_sel),       16'h1);
        check("addi_imm",    imm,                16'hFFFF);
        check("addi_rdest",  16'(rdest_reg_loc), 16'h3);
        check("addi_aluop",  16'(alu_op),        16'(ALU_ADD));
        check("addi_pc_ex",  pc_out,             16'h0000);
        tick();
        check("addi_pc",     pc_out,             16'h0001);
        check("addi_f_regen",16'(reg_en),        16'h0);

        // ADD R1,R2 (register form) at PC 0001
        instr = 16'h0152;
        tick();
        tick();
        check("add_regen",  16'(reg_en),       16'h1);
        check("add_flgen",  16'(flags_en),     16'h1);
        check("add_immsel", 16'(imm_sel),      16'h0);
        check("add_aluop",  16'(alu_op),       16'(ALU_ADD));
        check("add_rsrc",   16'(rsrc_reg_loc), 16'h2);
        tick();
        check("add_pc",     pc_out,            16'h0002);

        // CMPI R4,#0x80 at PC 0002: sign-extended, flags only
        instr = 16'hB480;
        tick();
        tick();
        check("cmpi_regen", 16'(reg_en),   16'h0);
        check("cmpi_flgen", 16'(flags_en), 16'h1);
        check("cmpi_imm",   imm,           16'hFF80);
        check("cmpi_aluop", 16'(alu_op),   16'(ALU_SUB));
        tick();
        check("cmpi_pc",    pc_out,        16'h0003);

        // ORI R5,#0x80 at PC 0003: zero-extended, no flags
        instr = 16'h2580;
        tick();
        tick();
        check("ori_regen", 16'(reg_en),   16'h1);
        check("ori_flgen", 16'(flags_en), 16'h0);
        check("ori_imm",   imm,           16'h0080);
        check("ori_aluop", 16'(alu_op),   16'(ALU_OR));
        tick();
        check("ori_pc",    pc_out,        16'h0004);

        // LOAD R2,[R7] at PC 0004: four cycles, write in MEM
        instr = 16'h4207;
        tick();
        tick();
        check("load_ex_regen", 16'(reg_en),       16'h0);
        check("load_ex_m2r",   16'(mem_to_reg),   16'h0);
        check("load_ex_memwe", 16'(mem_we),       16'h0);
        check("load_ex_rsrc",  16'(rsrc_reg_loc), 16'h7);
        tick();
        check("load_mem_m2r",  16'(mem_to_reg),   16'h1);
        check("load_mem_regen",16'(reg_en),       16'h1);
        check("load_mem_rdest",16'(rdest_reg_loc),16'h2);
        check("load_mem_pc",   pc_out,            16'h0004);
        tick();
        check("load_pc",       pc_out,            16'h0005);
        check("load_f_regen",  16'(reg_en),       16'h0);

        // STOR R2,[R7] at PC 0005: one MemWe pulse, no RegEn
        instr = 16'h4247;
        tick();
        check("stor_dec_memwe", 16'(mem_we), 16'h0);
        tick();
        check("stor_memwe", 16'(mem_we), 16'h1);
        check("stor_regen", 16'(reg_en), 16'h0);
        tick();
        check("stor_f_memwe", 16'(mem_we), 16'h0);
        check("stor_pc",      pc_out,      16'h0006);

        // Branches
        run_branch("uc_to_10",  16'hCE0A, 5'b00000, 16'h0010);
        run_branch("beq_z1",    16'hC0FE, 5'b00010, 16'h000E);
        run_branch("uc_back",   16'hCE02, 5'b00000, 16'h0010);
        run_branch("beq_z0",    16'hC0FE, 5'b00000, 16'h0011);
        run_branch("never",     16'hCF10, 5'b11111, 16'h0012);
        run_branch("lo_take",   16'hCA05, 5'b00000, 16'h0017);
        run_branch("ge_fall",   16'hCD05, 5'b00000, 16'h0018);
        run_branch("uc_to_ffff",16'hCEE7, 5'b00000, 16'hFFFF);
        run_branch("uc_wrap",   16'hCE01, 5'b00000, 16'h0000);
        run_branch("hi_take",   16'hC403, 5'b01000, 16'h0003);

        // Reset asserted during EXEC of ADD aborts the write
        flags = 5'b00000;
        instr = 16'h0152;
        tick();
        tick();
        check("abort_pre_regen", 16'(reg_en), 16'h1);
        rst = 1'b1;
        #1;
        check("abort_regen", 16'(reg_en),   16'h0);
        check("abort_flgen", 16'(flags_en), 16'h0);
        check("abort_pc",    pc_out,        16'h0000);
        tick();
        check("abort_hold_regen", 16'(reg_en), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_rel_pc", pc_out, 16'h0000);

        // MOVI R0,#5: write to R0 is a normal write
        instr = 16'hD005;
        tick();
        tick();
        check("movi_regen", 16'(reg_en),        16'h1);
        check("movi_flgen", 16'(flags_en),      16'h0);
        check("movi_aluop", 16'(alu_op),        16'(ALU_MOV));
        check("movi_imm",   imm,                16'h0005);
        check("movi_rdest", 16'(rdest_reg_loc), 16'h0);
        tick();
        check("movi_pc",    pc_out,             16'h0001);

        // Illegal opcode 0xF000 at PC 0001: trap and freeze
        instr = 16'hF000;
        tick();
        check("ill_dec_halt", 16'(halt), 16'h0);
        tick();
        instr = 16'h53FF;
        for (int i = 0; i < 20; i++) begin
            check("ill_halt",  16'(halt),     16'h1);
            check("ill_pc",    pc_out,        16'h0001);
            check("ill_regen", 16'(reg_en),   16'h0);
            check("ill_flgen", 16'(flags_en), 16'h0);
            tick();
        end

        // Reset exits HALT; illegal register-form ext 0000 also traps
        rst = 1'b1;
        #1;
        check("ill_rst_halt", 16'(halt), 16'h0);
        @(negedge clk);
        rst   = 1'b0;
        instr = 16'h0100;
        tick();
        tick();
        check("illrr_halt", 16'(halt),   16'h1);
        check("illrr_pc",   pc_out,      16'h0000);
        check("illrr_memwe",16'(mem_we), 16'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
